// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Read-side initiator for main memory. Issues word-aligned reads, captures
//   the returned instruction words into a small first-word-fallthrough
//   prefetch FIFO and hands them, with their PCs, to decode over valid/ready.
//   A redirect pulse flushes buffered and in-flight fetches and restarts
//   fetch at the new PC.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   mem_read          read strobe to main memory
//   mem_addr          byte address to main memory
//   mem_data          read data from main memory
//   redirect_valid    one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc       new fetch address, low two bits ignored
//   instr_valid       FIFO head valid
//   instr, instr_pc   FIFO head word and its byte address
//   instr_ready       decode accepts the head this cycle
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W     = 17,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       MEM_LAT    = 1,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] fetch_pc;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              last_cycle;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_next;

  always_comb begin
    last_cycle = (wait_cnt == WAIT_W'(MEM_LAT - 1));
    pop        = (count != '0) && instr_ready;
    // A redirect in the sampling cycle aborts the access, so nothing is pushed.
    push       = (state == S_REQ) && last_cycle && !redirect_valid;
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  assign instr_valid = (count != '0);
  assign instr       = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

  // Gated by rst so the strobe is low during reset cycles yet rises in the
  // very first cycle after rst drops (the reset state is already S_REQ).
  assign mem_read = (state == S_REQ) && !rst;

  // S_HOLD is only entered right after a capture advanced fetch_pc, so the
  // address of the last access is fetch_pc - 4.
  assign mem_addr = (state == S_HOLD) ? (fetch_pc - ADDR_W'(4)) : fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      wait_cnt <= '0;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      state    <= S_REQ;
      wait_cnt <= '0;
      fetch_pc <= redirect_pc & ~ADDR_W'(3);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_data;
        fifo_pc[wr_ptr]   <= fetch_pc;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;

      case (state)
        S_REQ: begin
          if (last_cycle) begin
            wait_cnt <= '0;
            fetch_pc <= fetch_pc + ADDR_W'(4);
            // Only start the next access if a slot is free for it.
            state    <= (count_next < CNT_W'(FIFO_DEPTH)) ? S_REQ : S_HOLD;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_HOLD: begin
          if (pop) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, a directed vector table, hand-written latency/reset sequences
// and a randomized run checked against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a: MEM_LAT=1
  logic              a_rst = 1'b1, a_rdy = 1'b0, a_rv = 1'b0;
  logic [ADDR_W-1:0] a_rpc = '0;
  logic              a_read, a_valid;
  logic [ADDR_W-1:0] a_addr, a_pc;
  logic [DATA_W-1:0] a_data, a_instr;
  // instance b: MEM_LAT=3
  logic              b_rst = 1'b1, b_rdy = 1'b0, b_rv = 1'b0;
  logic [ADDR_W-1:0] b_rpc = '0;
  logic              b_read, b_valid;
  logic [ADDR_W-1:0] b_addr, b_pc;
  logic [DATA_W-1:0] b_data, b_instr;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH),
                     .MEM_LAT(1), .RESET_PC(17'h0)) dut_a (
    .clk(clk), .rst(a_rst), .mem_read(a_read), .mem_addr(a_addr),
    .mem_data(a_data), .redirect_valid(a_rv), .redirect_pc(a_rpc),
    .instr_valid(a_valid), .instr(a_instr), .instr_pc(a_pc),
    .instr_ready(a_rdy));

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH),
                     .MEM_LAT(3), .RESET_PC(17'h0)) dut_b (
    .clk(clk), .rst(b_rst), .mem_read(b_read), .mem_addr(b_addr),
    .mem_data(b_data), .redirect_valid(b_rv), .redirect_pc(b_rpc),
    .instr_valid(b_valid), .instr(b_instr), .instr_pc(b_pc),
    .instr_ready(b_rdy));

  // Memory returns an address-tagged word; garbage when not being read.
  function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
    return {~a[14:0], a};
  endfunction

  assign a_data = a_read ? word(a_addr) : 32'hDEAD_BEEF;
  assign b_data = b_read ? word(b_addr) : 32'hDEAD_BEEF;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input int k, input logic r, input logic rd, input logic rv,
                       input logic [ADDR_W-1:0] rp);
    if (k == 0) begin
      a_rst = r; a_rdy = rd; a_rv = rv; a_rpc = rp;
    end else begin
      b_rst = r; b_rdy = rd; b_rv = rv; b_rpc = rp;
    end
  endtask

  logic              o_read, o_valid;
  logic [ADDR_W-1:0] o_addr, o_pc;
  logic [DATA_W-1:0] o_instr;

  task automatic sample(input int k);
    if (k == 0) begin
      o_read = a_read; o_valid = a_valid; o_addr = a_addr; o_pc = a_pc; o_instr = a_instr;
    end else begin
      o_read = b_read; o_valid = b_valid; o_addr = b_addr; o_pc = b_pc; o_instr = b_instr;
    end
  endtask

  typedef struct {
    logic              rst;
    logic              rdy;
    logic              rv;
    logic [ADDR_W-1:0] rpc;
    logic              e_read;
    logic [ADDR_W-1:0] e_addr;
    logic              e_valid;
    logic [ADDR_W-1:0] e_pc;
  } vec_t;

  vec_t tbl [29];

  // Reference model state (transaction level: a queue of buffered PCs).
  logic [ADDR_W-1:0] m_q [$];
  logic [ADDR_W-1:0] m_pc;
  bit                m_stall;
  int unsigned       m_age;

  initial begin
    logic              r, rd, rv, popped, exp_read;
    logic [ADDR_W-1:0] rp;
    int unsigned       lat, pct;

    //            rst   rdy   rv    rpc        read  addr       valid pc
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 17'h0,     1'b0, 17'h0,     1'b0, 17'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 17'h0,     1'b1, 17'h0,     1'b0, 17'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 17'h0,     1'b1, 17'h4,     1'b1, 17'h0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 17'h0,     1'b1, 17'h8,     1'b1, 17'h0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 17'h0,     1'b1, 17'hC,     1'b1, 17'h0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 17'h0,     1'b0, 17'h0,     1'b1, 17'h0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 17'h0,     1'b0, 17'h0,     1'b1, 17'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b0, 17'h0,     1'b1, 17'h0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 17'h0,     1'b1, 17'h10,    1'b1, 17'h4};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 17'h0,     1'b0, 17'h0,     1'b1, 17'h4};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b0, 17'h0,     1'b1, 17'h4};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b1, 17'h14,    1'b1, 17'h8};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b1, 17'h18,    1'b1, 17'hC};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 17'h0102,  1'b1, 17'h1C,    1'b1, 17'h10};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b1, 17'h100,   1'b0, 17'h0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 17'h0,     1'b1, 17'h104,   1'b1, 17'h100};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b1, 17'h108,   1'b1, 17'h100};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 17'h1FFFB, 1'b1, 17'h10C,   1'b1, 17'h104};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b1, 17'h1FFF8, 1'b0, 17'h0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b1, 17'h1FFFC, 1'b1, 17'h1FFF8};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b1, 17'h0,     1'b1, 17'h1FFFC};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b1, 17'h4,     1'b1, 17'h0};
    tbl[22] = '{1'b0, 1'b1, 1'b1, 17'h40,    1'b1, 17'h8,     1'b1, 17'h4};
    tbl[23] = '{1'b0, 1'b1, 1'b1, 17'h80,    1'b1, 17'h40,    1'b0, 17'h0};
    tbl[24] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b1, 17'h80,    1'b0, 17'h0};
    tbl[25] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b1, 17'h84,    1'b1, 17'h80};
    tbl[26] = '{1'b1, 1'b1, 1'b1, 17'h200,   1'b0, 17'h0,     1'b1, 17'h84};
    tbl[27] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b1, 17'h0,     1'b0, 17'h0};
    tbl[28] = '{1'b0, 1'b1, 1'b0, 17'h0,     1'b1, 17'h4,     1'b1, 17'h0};

    repeat (2) @(posedge clk);

    // ---- directed table on the MEM_LAT=1 instance ----
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      drive(0, tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      #1;
      sample(0);
      check("tbl_read", 32'(o_read), 32'(tbl[i].e_read));
      if (tbl[i].e_read) check("tbl_addr", 32'(o_addr), 32'(tbl[i].e_addr));
      check("tbl_valid", 32'(o_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        check("tbl_pc", 32'(o_pc), 32'(tbl[i].e_pc));
        check("tbl_instr", o_instr, word(tbl[i].e_pc));
      end
    end
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, '0);

    // ---- MEM_LAT=3: each address held 3 cycles, one word per 3 cycles ----
    drive(1, 1'b1, 1'b1, 1'b0, '0);
    #1;
    sample(1);
    check("l3_rst_read", 32'(o_read), 32'd0);
    check("l3_rst_valid", 32'(o_valid), 32'd0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(1, 1'b0, 1'b1, 1'b0, '0);
      #1;
      sample(1);
      check("l3_read", 32'(o_read), 32'd1);
      check("l3_addr", 32'(o_addr), 32'(4 * (i / 3)));
      check("l3_valid", 32'(o_valid), 32'((i >= 3) && (i % 3 == 0)));
      if ((i >= 3) && (i % 3 == 0)) check("l3_pc", 32'(o_pc), 32'(4 * (i / 3 - 1)));
    end
    // reset lands on the sampling cycle of the access to 0x14
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b0, '0);
    #1;
    sample(1);
    check("l3_midrst_read", 32'(o_read), 32'd0);
    check("l3_midrst_valid", 32'(o_valid), 32'd0);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      drive(1, 1'b0, 1'b1, 1'b0, '0);
      #1;
      sample(1);
      check("l3r_read", 32'(o_read), 32'd1);
      check("l3r_addr", 32'(o_addr), 32'(4 * (j / 3)));
      check("l3r_valid", 32'(o_valid), 32'((j >= 3) && (j % 3 == 0)));
      if ((j >= 3) && (j % 3 == 0)) check("l3r_pc", 32'(o_pc), 32'(4 * (j / 3 - 1)));
    end

    // ---- randomized run against the reference model, both instances ----
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 1 : 3;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 1'b0, '0);
      drive(1, 1'b1, 1'b0, 1'b0, '0);
      @(posedge clk);
      m_q.delete();
      m_pc    = '0;
      m_stall = 1'b0;
      m_age   = 0;
      for (int c = 0; c < 2500; c++) begin
        @(negedge clk);
        case ((c / 128) % 4)
          0:       pct = 100;
          1:       pct = 10;
          2:       pct = 60;
          default: pct = 35;
        endcase
        r  = ($urandom_range(0, 299) == 0);
        rd = ($urandom_range(0, 99) < pct);
        rv = ($urandom_range(0, 39) == 0);
        rp = ($urandom_range(0, 3) == 0) ? (17'h1FFF0 + ADDR_W'($urandom_range(0, 15)))
                                         : ADDR_W'($urandom);
        drive(k, r, rd, rv, rp);
        #1;
        sample(k);
        exp_read = !r && !m_stall;
        check("rnd_read", 32'(o_read), 32'(exp_read));
        if (exp_read) check("rnd_addr", 32'(o_addr), 32'(m_pc));
        check("rnd_valid", 32'(o_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
          check("rnd_pc", 32'(o_pc), 32'(m_q[0]));
          check("rnd_instr", o_instr, word(m_q[0]));
        end
        @(posedge clk);
        if (r) begin
          m_q.delete();
          m_pc = '0; m_stall = 1'b0; m_age = 0;
        end else if (rv) begin
          m_q.delete();
          m_pc = rp & ~17'h3; m_stall = 1'b0; m_age = 0;
        end else begin
          popped = (m_q.size() != 0) && rd;
          if (popped) void'(m_q.pop_front());
          if (!m_stall) begin
            if (m_age == lat - 1) begin
              m_q.push_back(m_pc);
              m_pc    = m_pc + 17'd4;
              m_age   = 0;
              m_stall = (m_q.size() == int'(DEPTH));
            end else begin
              m_age++;
            end
          end else if (popped) begin
            m_stall = 1'b0;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
